// File: rtl/uart_tx_fifo_sequencer.sv
// Drains bytes from the TX FIFO and hands them one at a time to the UART
// transmitter. Guards the FIFO read port against underflow and reports the
// sent-byte count and ack-timeout status to the register block.
module uart_tx_fifo_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_err,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic                  timeout_err
);

  localparam int unsigned AckW = $clog2(((ACK_TIMEOUT > 0) ? ACK_TIMEOUT : 1) + 1);
  localparam int unsigned GapW = $clog2(((GAP_CYCLES > 0) ? GAP_CYCLES : 1) + 1);

  typedef enum logic [2:0] {StIdle, StPop, StLatch, StStart, StSend, StGap} state_e;

  // Where a finished (or timed-out) byte goes: the gap is skipped entirely when it is zero.
  localparam state_e AfterTx = (GAP_CYCLES == 0) ? StIdle : StGap;

  state_e                state_q, state_d;
  logic [AckW-1:0]       ack_cnt_q, ack_cnt_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                  fifo_rd_en_q, fifo_rd_en_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  tx_count_q, tx_count_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  count_inc;
  logic                  timeout_set;
  logic                  gap_last;
  logic                  count_sat;

  assign gap_last  = (32'(gap_cnt_q) + 32'd1) >= GAP_CYCLES;
  assign count_sat = (tx_count_q == {CNT_WIDTH{1'b1}});

  // Next-state and next-output logic; every output is taken from a register below.
  always_comb begin
    state_d      = state_q;
    ack_cnt_d    = ack_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    fifo_rd_en_d = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    count_inc    = 1'b0;
    timeout_set  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // tx_busy may be held by another source; never start under it.
        if (en && !fifo_empty && !tx_busy) begin
          fifo_rd_en_d = 1'b1;
          state_d      = StPop;
        end
      end
      StPop: begin
        state_d = StLatch;
      end
      StLatch: begin
        tx_data_d = fifo_data;
        state_d   = StStart;
      end
      StStart: begin
        if (tx_busy) begin
          count_inc = 1'b1;
          state_d   = StSend;
        end else if (ack_cnt_q == AckW'(ACK_TIMEOUT)) begin
          timeout_set = 1'b1;
          state_d     = AfterTx;
        end else begin
          ack_cnt_d  = ack_cnt_q + AckW'(1);
          tx_start_d = 1'b1;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          state_d = AfterTx;
        end
      end
      StGap: begin
        if (gap_last) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Both counters restart from zero on every state entry.
    if (state_d != state_q) begin
      ack_cnt_d = '0;
      gap_cnt_d = '0;
    end

    busy_d = (state_d != StIdle);

    // Clear beats a coincident increment; a coincident timeout beats the clear.
    if (clr_err) begin
      tx_count_d = '0;
    end else if (count_inc && !count_sat) begin
      tx_count_d = tx_count_q + CNT_WIDTH'(1);
    end else begin
      tx_count_d = tx_count_q;
    end

    if (timeout_set) begin
      timeout_err_d = 1'b1;
    end else if (clr_err) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // State, counter and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      ack_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      fifo_rd_en_q  <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      tx_count_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ack_cnt_q     <= ack_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      fifo_rd_en_q  <= fifo_rd_en_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      tx_count_q    <= tx_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign fifo_rd_en  = fifo_rd_en_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign tx_count    = tx_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
// Bench for uart_tx_fifo_sequencer: FIFO and UART behavioural models, a
// scoreboard of bytes the UART should see, and a decoupled output monitor.
module tb_uart_tx_fifo_sequencer;

  localparam int Gap    = 16;
  localparam int AckTo  = 64;
  localparam int CntW   = 3;
  localparam int CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            clr_err = 1'b0;
  logic            fifo_empty = 1'b1;
  logic            fifo_rd_en;
  logic [7:0]      fifo_data = 8'h00;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy = 1'b0;
  logic            busy;
  logic [CntW-1:0] tx_count;
  logic            timeout_err;

  logic            push_valid = 1'b0;
  logic [7:0]      push_byte = 8'h00;
  logic            uart_ack = 1'b1;
  logic            gap_chk = 1'b0;

  int              cyc = 0;
  int              checks = 0;
  int              failures = 0;
  int              acked = 0;
  int              total_push = 0;
  int              rd_cnt = 0;
  int              start_hi = 0;
  logic [7:0]      exp_q[$];
  logic [7:0]      fq[$];

  uart_tx_fifo_sequencer #(
    .DATA_WIDTH (8),
    .GAP_CYCLES (Gap),
    .ACK_TIMEOUT(AckTo),
    .CNT_WIDTH  (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr_err    (clr_err),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .tx_count   (tx_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO model with registered data output and empty flag.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
    if (push_valid) fq.push_back(push_byte);
    fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int exp_count();
    return (acked > CntMax) ? CntMax : acked;
  endfunction

  // UART model: raises tx_busy two cycles after seeing tx_start, holds it ten cycles.
  task automatic uart_model();
    forever begin
      @(negedge clk);
      if (uart_ack && tx_start && !tx_busy) begin
        repeat (2) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  endtask

  // Monitor: compares each presented byte with the scoreboard and checks pop discipline.
  task automatic monitor();
    logic prev_rd = 1'b0;
    logic prev_start = 1'b0;
    logic prev_tb = 1'b0;
    int   rd_cyc = 0;
    int   fall_cyc = -1;
    forever begin
      @(negedge clk);
      if (tx_start) start_hi++;
      if (fifo_rd_en) begin
        chk("rd_pulse_width", int'(prev_rd), 0);
        chk("rd_while_empty", int'(fifo_empty), 0);
      end
      if (fifo_rd_en && !prev_rd) begin
        rd_cnt++;
        // SEND->GAP edge, Gap cycles of gap, one IDLE cycle before the pop.
        if (gap_chk && fall_cyc >= 0) chk("gap_spacing", cyc - fall_cyc, Gap + 2);
        fall_cyc = -1;
        rd_cyc   = cyc;
      end
      if (prev_tb && !tx_busy) fall_cyc = cyc;
      if (tx_start && !prev_start) begin
        chk("rd_to_start_latency", cyc - rd_cyc, 3);
        if (exp_q.size() == 0) chk("scoreboard_has_entry", 0, 1);
        else chk("tx_data", int'(tx_data), int'(exp_q.pop_front()));
      end
      prev_rd    = fifo_rd_en;
      prev_start = tx_start;
      prev_tb    = tx_busy;
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_byte  = b;
    push_valid = 1'b1;
    exp_q.push_back(b);
    total_push++;
    if (uart_ack) acked++;
    @(posedge clk);
    #1 push_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n = 0;
    while (!(!busy && fifo_empty && !tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_in_budget"}, int'(n < budget), 1);
  endtask

  task automatic wait_send(input logic [7:0] b, input string tag);
    int n = 0;
    while (!(tx_busy && busy && tx_data == b) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_send_reached"}, int'(n < 400), 1);
  endtask

  initial begin
    int rd0;
    int s0;
    int bad;
    fork
      monitor();
      uart_model();
    join_none

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_fifo_rd_en", int'(fifo_rd_en), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_count", int'(tx_count), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    en = 1'b1;

    // Three directed bytes with full gap spacing.
    gap_chk = 1'b1;
    rd0 = rd_cnt;
    push(8'hA5);
    push(8'h3C);
    push(8'hFF);
    wait_quiet(400, "directed");
    gap_chk = 1'b0;
    chk("directed_pops", rd_cnt - rd0, 3);
    chk("directed_tx_count", int'(tx_count), 3);
    chk("directed_sb_drained", exp_q.size(), 0);

    // Empty FIFO: nothing happens.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en || busy) bad++;
    end
    chk("empty_fifo_quiet", bad, 0);

    // UART never acknowledges.
    uart_ack = 1'b0;
    s0 = start_hi;
    @(posedge clk);
    #1 push(8'h55);
    wait_quiet(400, "timeout");
    chk("timeout_start_cycles", start_hi - s0, AckTo);
    chk("timeout_err_set", int'(timeout_err), 1);
    chk("timeout_count_kept", int'(tx_count), exp_count());
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    acked = 0;
    chk("clr_timeout_err", int'(timeout_err), 0);
    chk("clr_tx_count", int'(tx_count), 0);
    uart_ack = 1'b1;

    // Drop en mid-SEND: current byte finishes, next byte stays queued.
    rd0 = rd_cnt;
    push(8'h11);
    push(8'h22);
    wait_send(8'h11, "en_drop");
    en = 1'b0;
    repeat (Gap + 40) @(negedge clk);
    chk("en_drop_busy", int'(busy), 0);
    chk("en_drop_pops", rd_cnt - rd0, 1);
    chk("en_drop_fifo_held", int'(fifo_empty), 0);
    chk("en_drop_count", int'(tx_count), 1);
    @(posedge clk);
    #1 en = 1'b1;
    wait_quiet(400, "en_resume");
    chk("en_resume_pops", rd_cnt - rd0, 2);
    chk("en_resume_count", int'(tx_count), exp_count());

    // Reset mid-SEND: outputs clear at once, next queued byte follows.
    push(8'h77);
    push(8'h88);
    wait_send(8'h77, "rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_fifo_rd_en", int'(fifo_rd_en), 0);
    chk("midrst_tx_start", int'(tx_start), 0);
    chk("midrst_tx_data", int'(tx_data), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_tx_count", int'(tx_count), 0);
    chk("midrst_timeout_err", int'(timeout_err), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    acked = 1;
    wait_quiet(400, "rst_resume");
    chk("rst_resume_count", int'(tx_count), exp_count());
    chk("rst_resume_sb_drained", exp_q.size(), 0);

    // Random traffic; tx_count must saturate at all-ones.
    rd0 = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      int w;
      push(8'($urandom_range(0, 255)));
      w = $urandom_range(0, 30);
      repeat (w) begin
        @(posedge clk);
        #1;
      end
    end
    wait_quiet(3000, "random");
    chk("random_pops", rd_cnt - rd0, 20);
    chk("random_sb_drained", exp_q.size(), 0);
    chk("saturated_tx_count", int'(tx_count), exp_count());
    chk("saturated_is_max", int'(tx_count), CntMax);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
